// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: register-address constants and queue entry layout.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  localparam int WB_XLEN = 32;

  // The entry data width tracks WB_XLEN; instantiate the arbiter with XLEN equal to it.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_XLEN-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_search.sv
// Youngest-first match over pending queue entries for one forwarding query port.
module wb_fwd_search
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = WB_XLEN
) (
  input  wb_entry_t [DEPTH-1:0]         entries,
  input  logic [DEPTH-1:0]              valid,
  input  logic [$clog2(DEPTH)-1:0]      tail,
  input  logic [REG_ADDR_W-1:0]         addr,
  output logic                          hit,
  output logic [XLEN-1:0]               data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk from tail-1 backwards; the first valid match is the youngest writer.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail - PW'(i + 1);
      if (!hit && valid[idx] && (addr != ZERO_REG) && (entries[idx].addr == addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Dual-lane writeback queue draining one entry per cycle into a single-port register file,
// with youngest-match forwarding lookups over the pending entries.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = WB_XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en1,
  input  logic [4:0]            dst1,
  input  logic [XLEN-1:0]       wb_data1,
  input  logic                  wb_en2,
  input  logic [4:0]            dst2,
  input  logic [XLEN-1:0]       wb_data2,
  output logic                  stall,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  input  logic [4:0]            fwd_addr_a,
  input  logic [4:0]            fwd_addr_b,
  output logic                  fwd_hit_a,
  output logic                  fwd_hit_b,
  output logic [XLEN-1:0]       fwd_data_a,
  output logic [XLEN-1:0]       fwd_data_b
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic       push1, push2;
  logic [1:0] n_push;

  // Flow control: stall is a function of registered count only. While stall=1 the lane
  // inputs are ignored; while stall=0 at least two free slots exist, so any lane pattern
  // presented that cycle is accepted in full.
  assign stall    = (count_q > CW'(DEPTH - 2));
  assign rf_we    = (count_q != '0);
  assign rf_waddr = entries_q[head_q].addr;
  assign rf_wdata = entries_q[head_q].data;

  // Lane 1 is dead when lane 2 overwrites the same register in the same cycle.
  assign push1  = !stall && wb_en1 && (dst1 != ZERO_REG) && !(wb_en2 && (dst2 == dst1));
  assign push2  = !stall && wb_en2 && (dst2 != ZERO_REG);
  assign n_push = {1'b0, push1} + {1'b0, push2};

  always_comb begin
    entries_d = entries_q;
    valid_d   = valid_q;
    head_d    = head_q;
    tail_d    = tail_q;

    if (rf_we) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PW'(1);
    end

    if (push1 && push2) begin
      entries_d[tail_q]          = '{addr: dst1, data: wb_data1};
      valid_d[tail_q]            = 1'b1;
      entries_d[tail_q + PW'(1)] = '{addr: dst2, data: wb_data2};
      valid_d[tail_q + PW'(1)]   = 1'b1;
      tail_d                     = tail_q + PW'(2);
    end else if (push1) begin
      entries_d[tail_q] = '{addr: dst1, data: wb_data1};
      valid_d[tail_q]   = 1'b1;
      tail_d            = tail_q + PW'(1);
    end else if (push2) begin
      entries_d[tail_q] = '{addr: dst2, data: wb_data2};
      valid_d[tail_q]   = 1'b1;
      tail_d            = tail_q + PW'(1);
    end

    count_d = count_q + CW'(n_push) - CW'(rf_we);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '0;
      valid_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      valid_q   <= valid_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  wb_fwd_search #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fwd_a (
    .entries (entries_q),
    .valid   (valid_q),
    .tail    (tail_q),
    .addr    (fwd_addr_a),
    .hit     (fwd_hit_a),
    .data    (fwd_data_a)
  );

  wb_fwd_search #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fwd_b (
    .entries (entries_q),
    .valid   (valid_q),
    .tail    (tail_q),
    .addr    (fwd_addr_b),
    .hit     (fwd_hit_b),
    .data    (fwd_data_b)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_en1, wb_en2;
  logic [4:0]      dst1, dst2;
  logic [XLEN-1:0] wb_data1, wb_data2;
  logic            stall, rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [4:0]      fwd_addr_a, fwd_addr_b;
  logic            fwd_hit_a, fwd_hit_b;
  logic [XLEN-1:0] fwd_data_a, fwd_data_b;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending writes in program order, oldest at index 0.
  logic [4:0]      m_addr[$];
  logic [XLEN-1:0] m_data[$];
  bit              started = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_en1     (wb_en1),
    .dst1       (dst1),
    .wb_data1   (wb_data1),
    .wb_en2     (wb_en2),
    .dst2       (dst2),
    .wb_data2   (wb_data2),
    .stall      (stall),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .fwd_addr_a (fwd_addr_a),
    .fwd_addr_b (fwd_addr_b),
    .fwd_hit_a  (fwd_hit_a),
    .fwd_hit_b  (fwd_hit_b),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Youngest pending write to a register, searched from the back of the model queue.
  task automatic model_lookup(input logic [4:0] a, output logic hit, output logic [XLEN-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != 5'd0) begin
      for (int i = m_addr.size() - 1; i >= 0; i--) begin
        if (m_addr[i] == a) begin
          hit = 1'b1;
          d   = m_data[i];
          break;
        end
      end
    end
  endtask

  task automatic check_outputs(input logic [4:0] fa, input logic [4:0] fb);
    logic            eh;
    logic [XLEN-1:0] ed;
    check("stall", stall, (m_addr.size() > DEPTH - 2));
    check("rf_we", rf_we, (m_addr.size() != 0));
    if (m_addr.size() != 0) begin
      check("rf_waddr", rf_waddr, m_addr[0]);
      check("rf_wdata", rf_wdata, m_data[0]);
    end
    model_lookup(fa, eh, ed);
    check("fwd_hit_a", fwd_hit_a, eh);
    if (eh || fa == 5'd0) check("fwd_data_a", fwd_data_a, ed);
    model_lookup(fb, eh, ed);
    check("fwd_hit_b", fwd_hit_b, eh);
    if (eh || fb == 5'd0) check("fwd_data_b", fwd_data_b, ed);
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then advance the model.
  task automatic cycle(input bit r,
                       input bit e1, input logic [4:0] a1, input logic [XLEN-1:0] d1,
                       input bit e2, input logic [4:0] a2, input logic [XLEN-1:0] d2,
                       input logic [4:0] fa, input logic [4:0] fb);
    bit accept;
    rst = r; wb_en1 = e1; dst1 = a1; wb_data1 = d1;
    wb_en2 = e2; dst2 = a2; wb_data2 = d2;
    fwd_addr_a = fa; fwd_addr_b = fb;
    #1;
    if (started) check_outputs(fa, fb);
    accept = (m_addr.size() <= DEPTH - 2);
    @(posedge clk);
    started = 1;
    if (r) begin
      m_addr.delete();
      m_data.delete();
    end else begin
      if (m_addr.size() != 0) begin
        void'(m_addr.pop_front());
        void'(m_data.pop_front());
      end
      if (accept) begin
        if (e1 && a1 != 5'd0 && !(e2 && a2 == a1)) begin
          m_addr.push_back(a1);
          m_data.push_back(d1);
        end
        if (e2 && a2 != 5'd0) begin
          m_addr.push_back(a2);
          m_data.push_back(d2);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] fa, input logic [4:0] fb);
    cycle(0, 0, 5'd0, '0, 0, 5'd0, '0, fa, fb);
  endtask

  initial begin
    rst = 1'b1;
    wb_en1 = 0; wb_en2 = 0; dst1 = 0; dst2 = 0; wb_data1 = 0; wb_data2 = 0;
    fwd_addr_a = 0; fwd_addr_b = 0;
    @(negedge clk);

    // Reset held two cycles with random lane traffic.
    repeat (2) cycle(1, 1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom_range(1, 31)), $urandom,
                     5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)));
    check("reset_rf_we", rf_we, 1'b0);
    check("reset_stall", stall, 1'b0);
    check("reset_hit_a", fwd_hit_a, 1'b0);
    idle(5'd5, 5'd0);

    // Program order: lane 1 drains before lane 2.
    cycle(0, 1, 5'd5, 32'h11, 1, 5'd6, 32'h22, 5'd5, 5'd6);
    check("order_first_addr", rf_waddr, 5'd5);
    idle(5'd5, 5'd6);
    check("order_second_data", rf_wdata, 32'h22);
    idle(5'd5, 5'd6);
    check("order_empty", rf_we, 1'b0);

    // Same destination on both lanes: only the younger survives.
    cycle(0, 1, 5'd7, 32'hAA, 1, 5'd7, 32'hBB, 5'd7, 5'd7);
    check("conflict_data", rf_wdata, 32'hBB);
    check("conflict_fwd", fwd_data_a, 32'hBB);
    idle(5'd7, 5'd0);
    check("conflict_single_write", rf_we, 1'b0);

    // x0 writes are filtered; x0 queries never hit.
    cycle(0, 1, 5'd0, 32'h1234, 1, 5'd3, 32'h55, 5'd3, 5'd0);
    check("x0_addr", rf_waddr, 5'd3);
    check("x0_fwd_b_hit", fwd_hit_b, 1'b0);
    idle(5'd3, 5'd0);

    // Back-pressure across pointer wrap, including ignored pushes under stall.
    cycle(0, 1, 5'd10, 32'hA0, 1, 5'd11, 32'hA1, 5'd10, 5'd11);
    cycle(0, 1, 5'd12, 32'hA2, 1, 5'd13, 32'hA3, 5'd12, 5'd13);
    check("bp_stall_on", stall, 1'b1);
    cycle(0, 1, 5'd14, 32'hDEAD, 1, 5'd15, 32'hBEEF, 5'd14, 5'd15);
    cycle(0, 1, 5'd16, 32'hA4, 1, 5'd17, 32'hA5, 5'd16, 5'd10);
    repeat (6) idle(5'd14, 5'd17);
    check("bp_drained", rf_we, 1'b0);

    // Forwarding priority: the younger x9 shadows the older one until it drains.
    cycle(0, 1, 5'd9, 32'h1, 1, 5'd20, 32'h7, 5'd9, 5'd20);
    cycle(0, 0, 5'd0, '0, 1, 5'd9, 32'h2, 5'd9, 5'd20);
    check("prio_young", fwd_data_a, 32'h2);
    repeat (3) idle(5'd9, 5'd9);
    check("prio_gone", fwd_hit_a, 1'b0);

    // Mid-operation reset discards pending entries.
    cycle(0, 1, 5'd21, 32'h21, 1, 5'd22, 32'h22, 5'd21, 5'd22);
    cycle(1, 1, 5'd23, 32'h23, 1, 5'd24, 32'h24, 5'd21, 5'd22);
    check("midreset_rf_we", rf_we, 1'b0);
    check("midreset_hit", fwd_hit_a, 1'b0);
    idle(5'd21, 5'd23);

    // Random traffic over a small register range to provoke collisions and stalls.
    for (int n = 0; n < 400; n++) begin
      cycle(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    repeat (6) idle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    check("final_empty", rf_we, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Sits between the dual-lane writeback stage and a register file with a single write port.
- Queues up to two writebacks per cycle, in program order (lane 1 older than lane 2), and drains one per cycle to the register file.
- Back-pressures the pipeline when the queue cannot take two more entries.
- Provides youngest-match forwarding lookups so that register reads never see stale register-file contents.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 4.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wb_en1  in  1  lane 1 (older) write request.
- dst1  in  5  lane 1 destination register.
- wb_data1  in  XLEN  lane 1 write data.
- wb_en2  in  1  lane 2 (younger) write request.
- dst2  in  5  lane 2 destination register.
- wb_data2  in  XLEN  lane 2 write data.
- stall  out  1  pipeline must hold; lane inputs are ignored this cycle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- fwd_addr_a, fwd_addr_b  in  5 each  forwarding query addresses.
- fwd_hit_a, fwd_hit_b  out  1 each  a pending queue entry matches the query.
- fwd_data_a, fwd_data_b  out  XLEN each  data of the youngest matching entry.

Behaviour:
- Reset:
  - Queue empty; head, tail and count are 0; all valid bits are 0.
  - rf_we=0, stall=0, fwd_hit_a/b=0.
  - Reset asserted mid-operation discards all pending entries; nothing is written to the register file.
- Queue structure:
  - Circular buffer of {addr, data}.
  - Head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- stall:
  - Combinational: stall = (count > DEPTH-2).
  - It depends only on registered count, never on current-cycle inputs.
- Enqueue (only when stall=0):
  - Requests with dst=0 are dropped.
  - If both lanes are enabled with the same nonzero dst, only lane 2 is enqueued (lane 1 is dead).
  - Otherwise lane 1 goes to slot tail and lane 2 to tail+1, or lane 2 alone to slot tail.
  - 0, 1 or 2 entries are pushed per cycle.
- Drain:
  - rf_we = (count != 0); rf_waddr/rf_wdata come combinationally from the head entry.
  - The head advances by 1 every cycle rf_we=1; the register file accepts unconditionally.
- Latency:
  - An entry pushed in cycle N reaches rf_we at cycle N+1 at the earliest (queue was empty).
  - Each older pending entry adds one cycle.
- Simultaneous push and drain: count_next = count + pushes - (rf_we ? 1 : 0).
- Forwarding:
  - Combinational search over valid entries only, from youngest (tail-1) toward head.
  - The first match gives hit=1 and that entry's data.
  - Query address 0 always gives hit=0, data=0.
  - Same-cycle incoming lanes are not searched; the pipeline forwards those itself.
  - The head entry being written this cycle still hits.
- Full boundary:
  - count never exceeds DEPTH, because stall guarantees at least 2 free slots whenever inputs are accepted.
  - Any push attempted while stall=1 is a protocol violation; the bench checks that it is ignored.

Decomposition:
- Package wb_pkg:
  - REG_ADDR_W=5 and ZERO_REG=5'd0.
  - Typedef wb_entry_t {addr[4:0], data[XLEN-1:0]}.
- Sub-module wb_fwd_search: youngest-first match over queue contents; instantiated twice, for ports a and b.

Test Plan:
- Reset: hold rst for 2 cycles with random lane inputs -> rf_we=0, stall=0, fwd_hit_a=0; after release, queue empty.
- Order: cycle 0 push lane1 (x5, 0x11) and lane2 (x6, 0x22) -> cycle 1 rf_we with x5/0x11; cycle 2 x6/0x22; cycle 3 rf_we=0.
- Same-destination conflict: both lanes x7 with 0xAA and 0xBB -> one write only, x7=0xBB; fwd_addr_a=7 gives hit with 0xBB.
- x0 filtering: lane1 x0 with 0x1234 and lane2 x3 with 0x55 -> only x3 is written; fwd_addr_b=0 gives hit=0.
- Back-pressure (DEPTH=4): push 2 entries per cycle for 3 cycles -> stall=1 from cycle 2 onward while count is 3 or 4; third-cycle inputs ignored; stall drops once count is 2 or less; every accepted entry is written exactly once, in order, across pointer wrap.
- Forwarding priority: enqueue x9=0x1 then x9=0x2 in later cycles while the first is still queued -> fwd_data_a=0x2 until the second entry drains; hit=0 after both drain.
